i2c_target_regfile: RTL and testbench

Parametrised I2C target (slave) with an internal byte-wide register file, replacing the fixed 9-register I2C block feeding the IO/PWM logic. Supports a configurable 7-bit address, configurable register count, register-pointer writes with auto-increment and wrap, reads with auto-increment, and repeated START. The packed register contents drive downstream IO exactly as before. Every write commit produces a one-cycle strobe.

---
 rtl/i2c_target_regfile.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, pointer auto-increment
// with wrap, repeated START and a one-cycle write strobe.
module i2c_target_regfile #(
    parameter logic [6:0] I2C_ADDR    = 7'h42,
    parameter int         NUM_REGS    = 9,
    parameter logic [7:0] RESET_VALUE = 8'h00,
    localparam int        PW          = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  SCL_in,
    input  logic                  SDA_in,
    output logic                  SDA_out,
    output logic [8*NUM_REGS-1:0] registers_packed,
    output logic                  wr_strobe,
    output logic [PW-1:0]         wr_index,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_q;
    logic       sda_q;
    logic       scl_rise_q;
    logic       scl_fall_q;
    logic       start_q;
    logic       stop_q;

    state_t        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_out_q, sda_out_d;
    logic          busy_q, busy_d;
    logic          rw_q, rw_d;
    logic          wr_strobe_q;
    logic [PW-1:0] wr_index_q;
    logic [7:0]    regs_q [NUM_REGS];

    logic          wr_en;
    logic [7:0]    rx_byte;
    logic [PW-1:0] ptr_inc;
    logic          ptr_ok;

    // Bus idles high, so the synchronizers reset high to avoid false edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL_in};
            sda_sync_q <= {sda_sync_q[0], SDA_in};
            scl_q      <= scl_sync_q[1];
            sda_q      <= sda_sync_q[1];
            scl_rise_q <= scl_sync_q[1] & ~scl_q;
            scl_fall_q <= ~scl_sync_q[1] & scl_q;
            start_q    <= scl_sync_q[1] & scl_q & sda_q & ~sda_sync_q[1];
            stop_q     <= scl_sync_q[1] & scl_q & ~sda_q & sda_sync_q[1];
        end
    end

    assign rx_byte = {shift_q[6:0], sda_q};
    assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_ok  = ({1'b0, rx_byte} < 9'(NUM_REGS));

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        wr_en     = 1'b0;
        if (stop_q) begin
            state_d   = S_IDLE;
            bit_d     = 4'd0;
            sda_out_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_q) begin
            state_d   = S_ADDR;
            bit_d     = 4'd0;
            sda_out_d = 1'b0;
        end else begin
            unique case (state_q)
                S_ADDR: if (scl_rise_q) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                            state_d = S_ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_PTR: if (scl_rise_q) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        if (ptr_ok) begin
                            ptr_d   = rx_byte[PW-1:0];
                            state_d = S_PTR_ACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_WDATA: if (scl_rise_q) begin
                    shift_d = rx_byte;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        wr_en   = 1'b1;
                        ptr_d   = ptr_inc;
                        state_d = S_WDATA_ACK;
                    end
                end
                // First fall after bit 8 drives ACK, the next one ends the slot.
                S_ADDR_ACK: if (scl_fall_q) begin
                    if (!sda_out_q) begin
                        sda_out_d = 1'b1;
                    end else begin
                        bit_d = 4'd0;
                        if (rw_q) begin
                            state_d   = S_RDATA;
                            shift_d   = regs_q[ptr_q];
                            sda_out_d = ~regs_q[ptr_q][7];
                        end else begin
                            state_d   = S_PTR;
                            sda_out_d = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: if (scl_fall_q) begin
                    if (!sda_out_q) begin
                        sda_out_d = 1'b1;
                    end else begin
                        sda_out_d = 1'b0;
                        bit_d     = 4'd0;
                        state_d   = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise_q) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            state_d = S_RDATA_ACK;
                        end
                    end else if (scl_fall_q) begin
                        if (bit_q == 4'd0) begin
                            sda_out_d = ~shift_q[7];
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_out_d = ~shift_q[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_fall_q) begin
                        sda_out_d = 1'b0;
                    end else if (scl_rise_q) begin
                        ptr_d = ptr_inc;
                        if (sda_q) begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_RDATA;
                            bit_d   = 4'd0;
                            shift_d = regs_q[ptr_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_q       <= 4'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            sda_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_en;
            if (wr_en) begin
                regs_q[ptr_q] <= rx_byte;
                wr_index_q    <= ptr_q;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
        assign registers_packed[8*i +: 8] = regs_q[i];
    end

    assign SDA_out   = sda_out_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus-level controller driving directed
// and random transactions against a transaction-level register model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;
    localparam int NR = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            scl = 1'b1;
    logic            sda_m = 1'b1;
    logic            sda_out;
    logic            sda_line;
    logic [8*NR-1:0] regs_p;
    logic            wr_strobe;
    logic [3:0]      wr_index;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl [NR];
    int         mptr;
    logic [7:0] wbuf [4];
    int         strobe_q[$];
    int         sda_hi_cnt = 0;

    assign sda_line = sda_m & ~sda_out;

    i2c_target_regfile #(
        .I2C_ADDR(7'h42), .NUM_REGS(NR), .RESET_VALUE(8'h00)
    ) dut (
        .clock(clk), .reset(rst), .SCL_in(scl), .SDA_in(sda_line),
        .SDA_out(sda_out), .registers_packed(regs_p),
        .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back(int'(wr_index));
        if (sda_out) sda_hi_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wt();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wt();
        scl = 1'b1; wt();
        sda_m = 1'b0; wt();
        scl = 1'b0; wt();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wt();
        scl = 1'b1; wt();
        sda_m = 1'b1; wt(); wt();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wt();
            scl = 1'b1; wt(); wt();
            scl = 1'b0; wt();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        send_bits(b, 8);
        sda_m = 1'b1; wt();
        scl = 1'b1; wt();
        ack = ~sda_line; wt();
        scl = 1'b0; wt();
    endtask

    task automatic read_byte(input bit ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wt();
            scl = 1'b1; wt();
            b[i] = sda_line; wt();
            scl = 1'b0;
        end
        wt();
        sda_m = ack ? 1'b0 : 1'b1; wt();
        scl = 1'b1; wt(); wt();
        scl = 1'b0; wt();
        sda_m = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        logic [8*NR-1:0] e;
        for (int i = 0; i < NR; i++) e[8*i +: 8] = mdl[i];
        check({tag, "/regs"}, regs_p, e);
    endtask

    task automatic xfer_write(input logic [7:0] p, input int n, input string tag);
        bit a;
        bit ok;
        int s0;
        int exp_s[$];
        s0 = strobe_q.size();
        i2c_start();
        write_byte(8'h84, a);
        check({tag, "/aack"}, a, 1);
        check({tag, "/busy"}, busy, 1);
        write_byte(p, a);
        ok = (int'(p) < NR);
        check({tag, "/pack"}, a, ok);
        if (ok) mptr = int'(p);
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], a);
            check({tag, "/dack"}, a, ok);
            if (ok) begin
                mdl[mptr] = wbuf[k];
                exp_s.push_back(mptr);
                mptr = (mptr + 1) % NR;
            end
        end
        i2c_stop();
        check({tag, "/nstb"}, strobe_q.size() - s0, exp_s.size());
        for (int k = 0; k < exp_s.size(); k++) begin
            if (s0 + k < strobe_q.size())
                check({tag, "/widx"}, strobe_q[s0 + k], exp_s[k]);
        end
        check({tag, "/idle"}, busy, 0);
        check_regs(tag);
    endtask

    task automatic xfer_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
        bit a;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h84, a);
            check({tag, "/wack"}, a, 1);
            write_byte(p, a);
            check({tag, "/pack"}, a, int'(p) < NR);
            if (int'(p) < NR) mptr = int'(p);
            i2c_start();
        end
        write_byte(8'h85, a);
        check({tag, "/rack"}, a, 1);
        for (int k = 0; k < n; k++) begin
            read_byte(k != n - 1, b);
            check({tag, "/rd"}, b, mdl[mptr]);
            mptr = (mptr + 1) % NR;
        end
        check({tag, "/rel"}, sda_out, 0);
        check({tag, "/nbusy"}, busy, 0);
        i2c_stop();
    endtask

    initial begin
        bit a;
        int s0;
        int h0;
        int waitc;
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
        mptr = 0;

        repeat (4) @(posedge clk);
        #1;
        check("rst/sda", sda_out, 0);
        check("rst/busy", busy, 0);
        check("rst/stb", wr_strobe, 0);
        check("rst/idx", wr_index, 0);
        check_regs("rst");
        rst = 1'b0;
        wt();

        wbuf[0] = 8'h55; wbuf[1] = 8'hAA;
        xfer_write(8'h02, 2, "write");

        s0 = strobe_q.size();
        h0 = sda_hi_cnt;
        i2c_start();
        write_byte(8'h86, a); check("badaddr/ack0", a, 0);
        write_byte(8'h00, a); check("badaddr/ack1", a, 0);
        write_byte(8'h11, a); check("badaddr/ack2", a, 0);
        i2c_stop();
        check("badaddr/sda", sda_hi_cnt - h0, 0);
        check("badaddr/nstb", strobe_q.size() - s0, 0);
        check_regs("badaddr");

        xfer_read(1, 8'h02, 2, "rdsr");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(8'h08, 2, "wrap");
        wbuf[0] = 8'h33;
        xfer_write(8'h09, 1, "badptr");
        xfer_read(0, 8'h00, 1, "ptrkeep");

        s0 = strobe_q.size();
        i2c_start();
        write_byte(8'h84, a); check("abort/aack", a, 1);
        write_byte(8'h05, a); check("abort/pack", a, 1);
        mptr = 5;
        send_bits(8'hF0, 4);
        i2c_stop();
        check("abort/nstb", strobe_q.size() - s0, 0);
        check("abort/busy", busy, 0);
        check_regs("abort");
        wbuf[0] = 8'h77;
        xfer_write(8'h05, 1, "after");

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                int n;
                n = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
                xfer_write(8'($urandom_range(0, NR + 2)), n, "rndw");
            end else begin
                xfer_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, NR + 1)),
                          $urandom_range(1, 3), "rndr");
            end
        end

        wbuf[0] = 8'h0F;
        xfer_write(8'h00, 1, "pre");
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h00, a);
        i2c_start();
        write_byte(8'h85, a);
        check("rstrd/ack", a, 1);
        waitc = 0;
        while (!sda_out && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("rstrd/drive", sda_out, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstrd/sda", sda_out, 0);
        check("rstrd/busy", busy, 0);
        check("rstrd/idx", wr_index, 0);
        for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
        mptr = 0;
        check_regs("rstrd");
        rst = 1'b0;
        sda_m = 1'b1;
        wt();
        scl = 1'b1;
        wt();
        wbuf[0] = 8'hC3;
        xfer_write(8'h04, 1, "post");
        xfer_read(1, 8'h04, 1, "postrd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
